fp_result_buffer: RTL
=====================

FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

Interface
REQ-001 Params SHALL be: DEPTH, default 4, FIFO entries (power of 2, >=2); TAG_WIDTH, default 0, tag width; STAT_WIDTH, default NUSFLAGS_DIV, status width.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 IssueValid_i  in  1  upstream issues an op into the divider this cycle (same signal as divider enable).
REQ-005 IssueReady_o  out  1  credit available; upstream issues only when high.
REQ-006 Valid_i  in  1  single-cycle divider result strobe.
REQ-007 Res_i  in  FP_WIDTH  divider result.
REQ-008 Status_i  in  STAT_WIDTH  divider status flags.
REQ-009 Tag_i  in  TAG_WIDTH  divider result tag.
REQ-010 Valid_o  out  1  head entry available.
REQ-011 Ready_i  in  1  consumer accepts head.
REQ-012 Res_o / Status_o / Tag_o  out  FP_WIDTH / STAT_WIDTH / TAG_WIDTH  head entry fields.
REQ-013 Empty_o, Full_o  out  1 each  FIFO occupancy flags.
REQ-014 Overflow_o  out  1  sticky error: result dropped.

Function
REQ-015 Storage SHALL be a DEPTH-entry circular FIFO of {Res, Status, Tag} with write pointer, read pointer and occupancy count (0..DEPTH).
REQ-016 Push SHALL occur when Valid_i=1 and (count<DEPTH or pop this cycle).
REQ-017 Pop SHALL occur when Valid_o=1 and Ready_i=1.
REQ-018 Valid_o SHALL equal count!=0; Res_o/Status_o/Tag_o SHALL show the entry at the read pointer; outputs are don't-care while empty.
REQ-019 Latency: result pushed at edge t SHALL be visible on Valid_o/Res_o in the cycle after edge t; no combinational Valid_i->Valid_o path.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 Valid_i with count=DEPTH and no pop SHALL drop the result, leave the FIFO unchanged and set Overflow_o.
REQ-023 In-flight counter (0..DEPTH): +1 on IssueValid_i&IssueReady_o, -1 on Valid_i; both in one cycle leaves it unchanged; decrement at 0 SHALL saturate at 0.
REQ-024 IssueReady_o SHALL be (count + inflight) < DEPTH, computed from registered state only; a same-cycle pop SHALL NOT raise it.
REQ-025 IssueValid_i while IssueReady_o=0 SHALL not change the in-flight counter.
REQ-026 Full_o = (count==DEPTH); Empty_o = (count==0).
REQ-027 Overflow_o SHALL stay set until reset.

Reset
REQ-028 While rst_ni=0: pointers, count and in-flight counter SHALL be 0; Valid_o=0; Empty_o=1; Full_o=0; Overflow_o=0; IssueReady_o=1; Res_o/Status_o/Tag_o=0.
REQ-029 Reset mid-operation SHALL discard all stored and in-flight results; results arriving after release with inflight=0 SHALL still be pushed if space exists.
REQ-030 Storage array SHALL not require reset.

Structure
REQ-031 FP_WIDTH and NUSFLAGS_DIV SHALL come from apu_cluster_package; a constant FP_RESBUF_DEPTH (=4) SHALL be added there as the default for DEPTH.
REQ-032 The block SHALL be a single module with no sub-modules; it sits directly downstream of the divider wrapper, whose Valid_o/Res_o/Status_o/Tag_o drive Valid_i/Res_i/Status_i/Tag_i.

Verification
REQ-033 Reset, then Valid_i with Res_i=0x3F800000, Tag_i=1, Ready_i=0 -> next cycle Valid_o=1, Res_o=0x3F800000, Tag_o=1, Empty_o=0.
REQ-034 Four pushes 0x1,0x2,0x3,0x4 with Ready_i=0 -> Full_o=1; then Ready_i=1 -> Res_o sequence 0x1,0x2,0x3,0x4 over 4 cycles, then Empty_o=1.
REQ-035 Full FIFO, Valid_i=1 and Ready_i=1 same cycle -> count stays 4, Overflow_o=0, new entry read last.
REQ-036 Full FIFO, Ready_i=0, Valid_i=1 -> entry dropped, Overflow_o=1 and stays 1 until rst_ni=0.
REQ-037 Four issues with no results (count=0) -> IssueReady_o=0 after the 4th; one Valid_i -> IssueReady_o still 0 (count=1, inflight=3); one pop -> IssueReady_o=1.
REQ-038 Assert rst_ni=0 with 2 stored and 2 in flight -> all outputs at reset values; after release, IssueReady_o=1.

Source files
------------

// File: rtl/apu_cluster_package.sv
// Shared APU cluster constants: FP datapath width, divider status width and
// the default depth of the FP divider result buffer.
package apu_cluster_package;

  localparam int unsigned FP_WIDTH        = 32'd32;
  localparam int unsigned NUSFLAGS_DIV    = 32'd5;
  localparam int unsigned FP_RESBUF_DEPTH = 32'd4;

  // Zero-width fields are carried as one unused bit so ports stay legal.
  function automatic int unsigned resbuf_field_w(input int unsigned w);
    return (w > 32'd0) ? w : 32'd1;
  endfunction

endpackage

// File: rtl/fp_result_buffer.sv
// Credit-controlled result FIFO behind the FP divider: results are queued until
// the consumer accepts them, and issue credit never exceeds the free entries.
module fp_result_buffer
  import apu_cluster_package::*;
#(
  parameter int unsigned DEPTH      = FP_RESBUF_DEPTH,
  parameter int unsigned TAG_WIDTH  = 32'd0,
  parameter int unsigned STAT_WIDTH = NUSFLAGS_DIV
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   IssueValid_i,
  output logic                                   IssueReady_o,
  input  logic                                   Valid_i,
  input  logic [FP_WIDTH-1:0]                    Res_i,
  input  logic [resbuf_field_w(STAT_WIDTH)-1:0]  Status_i,
  input  logic [resbuf_field_w(TAG_WIDTH)-1:0]   Tag_i,
  output logic                                   Valid_o,
  input  logic                                   Ready_i,
  output logic [FP_WIDTH-1:0]                    Res_o,
  output logic [resbuf_field_w(STAT_WIDTH)-1:0]  Status_o,
  output logic [resbuf_field_w(TAG_WIDTH)-1:0]   Tag_o,
  output logic                                   Empty_o,
  output logic                                   Full_o,
  output logic                                   Overflow_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 32'd1);
  localparam int unsigned STAT_W = resbuf_field_w(STAT_WIDTH);
  localparam int unsigned TAG_W  = resbuf_field_w(TAG_WIDTH);

  localparam logic [CNT_W-1:0] CNT_DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO_C  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE_C   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_LAST_C  = PTR_W'(DEPTH - 32'd1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST_C) ? PTR_ZERO_C : (p + PTR_ONE_C);
  endfunction

  logic [FP_WIDTH-1:0] res_mem_q  [DEPTH];
  logic [STAT_W-1:0]   stat_mem_q [DEPTH];
  logic [TAG_W-1:0]    tag_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             overflow_q, overflow_d;

  logic             valid_s;
  logic             pop_s;
  logic             push_s;
  logic             issue_s;
  logic             issue_ready_s;
  logic [CNT_W:0]   occupancy_s;

  assign valid_s       = (count_q != CNT_ZERO_C);
  assign pop_s         = valid_s && Ready_i;
  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign push_s        = Valid_i && ((count_q != CNT_DEPTH_C) || pop_s);
  // Credit uses registered occupancy only, so a pop cannot raise it combinationally.
  assign occupancy_s   = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue_ready_s = (occupancy_s < {1'b0, CNT_DEPTH_C});
  assign issue_s       = IssueValid_i && issue_ready_s;

  // Next-state for pointers, occupancy, in-flight credit and the sticky drop flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    overflow_d = overflow_q;

    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE_C;
      2'b01:   count_d = count_q - CNT_ONE_C;
      default: count_d = count_q;
    endcase

    case ({issue_s, Valid_i})
      2'b10: inflight_d = inflight_q + CNT_ONE_C;
      2'b01: begin
        if (inflight_q != CNT_ZERO_C) begin
          inflight_d = inflight_q - CNT_ONE_C;
        end else begin
          inflight_d = CNT_ZERO_C;
        end
      end
      default: inflight_d = inflight_q;
    endcase

    if (Valid_i && !push_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= PTR_ZERO_C;
      rd_ptr_q   <= PTR_ZERO_C;
      count_q    <= CNT_ZERO_C;
      inflight_q <= CNT_ZERO_C;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      res_mem_q[wr_ptr_q]  <= Res_i;
      stat_mem_q[wr_ptr_q] <= Status_i;
      tag_mem_q[wr_ptr_q]  <= Tag_i;
    end
  end

  assign IssueReady_o = issue_ready_s;
  assign Valid_o      = valid_s;
  assign Empty_o      = !valid_s;
  assign Full_o       = (count_q == CNT_DEPTH_C);
  assign Overflow_o   = overflow_q;
  // Head fields read as zero while empty, which also covers reset.
  assign Res_o        = valid_s ? res_mem_q[rd_ptr_q]  : {FP_WIDTH{1'b0}};
  assign Status_o     = valid_s ? stat_mem_q[rd_ptr_q] : {STAT_W{1'b0}};
  assign Tag_o        = valid_s ? tag_mem_q[rd_ptr_q]  : {TAG_W{1'b0}};

endmodule
